// File: rtl/alu_if.sv
// ---------------------------------------------------------------------------
// alu_if : operand/result bundle for the execute-stage ALU.
//   a, b     : 32-bit operands             (master -> slave)
//   ctrl     : 2-bit op select 00 add, 01 sub, 10 AND, 11 OR (master -> slave)
//   res      : 32-bit combinational result (slave -> master)
//   flags    : {N, Z, C, V} combinational  (slave -> master)
//   flags_q  : flags captured on last clk  (slave -> master)
// ---------------------------------------------------------------------------
interface alu_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  ctrl;
  logic [31:0] res;
  logic [3:0]  flags;
  logic [3:0]  flags_q;

  modport master (
    output a,
    output b,
    output ctrl,
    input  res,
    input  flags,
    input  flags_q
  );

  modport slave (
    input  a,
    input  b,
    input  ctrl,
    output res,
    output flags,
    output flags_q
  );
endinterface

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu : 32-bit combinational add/sub/AND/OR unit with {N, Z, C, V} flags and
//       a one-cycle flag status register for downstream condition checks.
//   clk   : rising-edge clock, clocks only the flag status register
//   reset : synchronous, active-low; clears flags_q only
//   bus   : alu_if slave port (a, b, ctrl in; res, flags, flags_q out)
// res and flags follow the inputs with no clock dependence, also in reset.
// ---------------------------------------------------------------------------
module alu (
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus
);

  // True when every bit of the word is clear.
  function automatic logic is_zero(input logic [31:0] word);
    is_zero = (word == 32'h0000_0000);
  endfunction

  logic [31:0] b_op_s;
  logic [32:0] sum33_s;
  logic [31:0] res_s;
  logic        carry_s;
  logic        ovf_s;
  logic [3:0]  flags_s;
  logic [3:0]  flags_r;

  // One shared 33-bit adder; subtract is a + ~b + 1 with the +1 from ctrl[0].
  always_comb begin
    b_op_s  = bus.ctrl[0] ? ~bus.b : bus.b;
    sum33_s = {1'b0, bus.a} + {1'b0, b_op_s} + {32'h0000_0000, bus.ctrl[0]};
  end

  // Result select; every ctrl code is a defined operation.
  always_comb begin
    res_s = 32'h0000_0000;
    case (bus.ctrl)
      2'b00:   res_s = sum33_s[31:0];
      2'b01:   res_s = sum33_s[31:0];
      2'b10:   res_s = bus.a & bus.b;
      2'b11:   res_s = bus.a | bus.b;
      default: res_s = 32'h0000_0000;
    endcase
  end

  // Carry and signed overflow exist only for arithmetic; logic ops force 0.
  // Overflow: operands (with b's sign inverted for sub) agree in sign but
  // the sum's sign differs from a.
  always_comb begin
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    if (bus.ctrl[1] == 1'b0) begin
      carry_s = sum33_s[32];
      ovf_s   = ~(bus.a[31] ^ bus.b[31] ^ bus.ctrl[0]) & (sum33_s[31] ^ bus.a[31]);
    end else begin
      carry_s = 1'b0;
      ovf_s   = 1'b0;
    end
  end

  // Assemble {N, Z, C, V}.
  always_comb begin
    flags_s = {res_s[31], is_zero(res_s), carry_s, ovf_s};
  end

  // Flag status register: synchronous active-low clear, else capture flags.
  always_ff @(posedge clk) begin
    if (reset == 1'b0) begin
      flags_r <= 4'h0;
    end else begin
      flags_r <= flags_s;
    end
  end

  assign bus.res     = res_s;
  assign bus.flags   = flags_s;
  assign bus.flags_q = flags_r;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu : self-checking bench for alu. Directed corner vectors, a reset
// sequence, then a randomized sweep compared against an arithmetic model.
// ---------------------------------------------------------------------------
module tb_alu;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare observed against expected, count it, report a mismatch.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide integer arithmetic, returns {res, N, Z, C, V}.
  function automatic logic [35:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    longint unsigned ua, ub, full;
    longint          sa, sb, sres;
    logic [31:0]     r;
    logic            c, v;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    r = 32'h0; c = 1'b0; v = 1'b0;
    case (op)
      2'b00: begin
        full = ua + ub;
        r    = full[31:0];
        c    = (full > 64'd4294967295);
        sres = sa + sb;
        v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      2'b01: begin
        full = ua - ub;
        r    = full[31:0];
        c    = (ua >= ub);
        sres = sa - sb;
        v    = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
      end
      2'b10: r = a & b;
      2'b11: r = a | b;
      default: r = 32'h0;
    endcase
    return {r, r[31], (r == 32'h0), c, v};
  endfunction

  // Drive on the falling edge, then check res/flags a little later mid-cycle.
  task automatic apply_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] op, output logic [3:0] exp_flags);
    logic [35:0] e;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.ctrl = op;
    #1;
    e = ref_model(a, b, op);
    exp_flags = e[3:0];
    check({tag, ".res"},   {32'h0, bus.res},   {32'h0, e[35:4]});
    check({tag, ".flags"}, {60'h0, bus.flags}, {60'h0, e[3:0]});
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] res;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [3:0]  ef;
    logic [3:0]  prev_flags;
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    n_checks = 0;
    n_errors = 0;

    // Directed vectors with hand-derived expectations.
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'h0000_0000, 4'h6};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 32'h8000_0000, 4'h9};
    vecs[2] = '{32'h0000_0005, 32'h0000_0005, 2'b01, 32'h0000_0000, 4'h6};
    vecs[3] = '{32'h0000_0000, 32'h0000_0001, 2'b01, 32'hFFFF_FFFF, 4'h8};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 2'b01, 32'h7FFF_FFFF, 4'h3};
    vecs[5] = '{32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b10, 32'h0000_0000, 4'h4};
    vecs[6] = '{32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b11, 32'hFFFF_FFFF, 4'h8};

    reset = 1'b0;
    bus.a = 32'hFFFF_FFFF; bus.b = 32'h0000_0001; bus.ctrl = 2'b00;

    // Reset held over two edges: flags_q stays 0 while flags is live.
    repeat (2) @(posedge clk);
    #1;
    check("rst.flags_q", {60'h0, bus.flags_q}, 64'h0);
    check("rst.flags",   {60'h0, bus.flags},   64'h6);
    check("rst.res",     {32'h0, bus.res},     64'h0);

    // Release: first edge with reset high captures current flags.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rel.flags_q", {60'h0, bus.flags_q}, 64'h6);

    // Directed table: literal expectations plus one-cycle flags_q check.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.a = vecs[i].a; bus.b = vecs[i].b; bus.ctrl = vecs[i].op;
      #1;
      check($sformatf("dir%0d.res", i),   {32'h0, bus.res},   {32'h0, vecs[i].res});
      check($sformatf("dir%0d.flags", i), {60'h0, bus.flags}, {60'h0, vecs[i].flags});
      @(posedge clk);
      #1;
      check($sformatf("dir%0d.flags_q", i), {60'h0, bus.flags_q}, {60'h0, vecs[i].flags});
    end

    // Reset mid-stream clears flags_q while flags keeps tracking.
    @(negedge clk);
    reset = 1'b0;
    apply_check("mid_rst", 32'h7FFF_FFFF, 32'h0000_0001, 2'b00, ef);
    @(posedge clk);
    #1;
    check("mid_rst.flags_q", {60'h0, bus.flags_q}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rel.flags_q", {60'h0, bus.flags_q}, 64'h9);

    // Randomized sweep, operands biased toward corner values.
    for (int i = 0; i < 1200; i++) begin
      case ($urandom_range(3, 0))
        0:       ra = 32'h8000_0000 - 32'($urandom_range(2, 0));
        1:       ra = 32'hFFFF_FFFF - 32'($urandom_range(2, 0));
        default: ra = $urandom;
      endcase
      case ($urandom_range(3, 0))
        0:       rb = 32'($urandom_range(2, 0));
        1:       rb = ra;
        default: rb = $urandom;
      endcase
      rop = 2'($urandom_range(3, 0));
      apply_check($sformatf("rnd%0d", i), ra, rb, rop, ef);
      prev_flags = ef;
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d.flags_q", i), {60'h0, bus.flags_q}, {60'h0, prev_flags});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
